// File: rtl/stack_unit_if.sv
// Stack command interface between the datapath controller and the operand stack.
// Pure wiring: carries one command per clock, with no latency of its own.
// No backpressure: the responder accepts a command every cycle.
interface stack_unit_if #(
    parameter int WIDTH = 8,
    parameter int PTR_W = 4
);
    logic             push;
    logic             pop;
    logic             tos;
    logic             clr_err;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic [PTR_W:0]   count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    // Controller side: issues strobes and data, and observes the stack state.
    modport master (
        output push, pop, tos, clr_err, din,
        input  dout, count, empty, full, overflow, underflow
    );

    // Stack side: responds to the strobes.
    modport slave (
        input  push, pop, tos, clr_err, din,
        output dout, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/stack_unit.sv
// Operand stack with a registered top-of-stack output and sticky error flags.
// Latency: each command completes at one edge; dout and count update on the next cycle.
// No backpressure: a command is accepted every cycle, and a rejected push or pop sets a sticky flag.
module stack_unit #(
    parameter int WIDTH = 8,
    parameter int PTR_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    stack_unit_if.slave   s
);
    localparam int             DEPTH   = 2 ** PTR_W;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] ONE     = (PTR_W + 1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W:0]   count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             is_empty;
    logic             is_full;
    logic [PTR_W:0]   count_m1;
    logic [PTR_W-1:0] top_idx;
    logic [PTR_W-1:0] push_idx;
    logic [WIDTH-1:0] top_val;
    logic             ovf_set;
    logic             unf_set;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == DEPTH_C);
    assign count_m1 = count_q - ONE;
    assign top_idx  = count_m1[PTR_W-1:0];
    assign push_idx = count_q[PTR_W-1:0];
    assign top_val  = mem_q[top_idx];

    // Resolve the command combination against the pre-edge array and count.
    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        dout_d  = dout_q;
        ovf_set = 1'b0;
        unf_set = 1'b0;

        // pop and tos both load the pre-edge top; on an empty stack neither touches dout.
        if ((s.pop || s.tos) && !is_empty) begin
            dout_d = top_val;
        end

        if (s.push && s.pop) begin
            if (!is_empty) begin
                // Replace the top in place; count is unchanged even when full.
                mem_d[top_idx] = s.din;
            end else begin
                // The pop has nothing to take, but the push still lands.
                unf_set  = 1'b1;
                mem_d[0] = s.din;
                count_d  = ONE;
            end
        end else if (s.push) begin
            if (!is_full) begin
                mem_d[push_idx] = s.din;
                count_d         = count_q + ONE;
            end else begin
                ovf_set = 1'b1;
            end
        end else if (s.pop) begin
            if (!is_empty) begin
                count_d = count_m1;
            end else begin
                unf_set = 1'b1;
            end
        end

        // A new error in the same cycle as clr_err wins for that flag.
        overflow_d  = (overflow_q  && !s.clr_err) || ovf_set;
        underflow_d = (underflow_q && !s.clr_err) || unf_set;
    end

    // Control state register; reset overrides any command issued in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            dout_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            dout_q      <= dout_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array is never cleared; a reset cycle only suppresses the pending write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q <= mem_d;
        end
    end

    assign s.dout      = dout_q;
    assign s.count     = count_q;
    assign s.empty     = is_empty;
    assign s.full      = is_full;
    assign s.overflow  = overflow_q;
    assign s.underflow = underflow_q;
endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit: each step queues its expected outcome, then checks it after the edge.
// Latency: one step per clock, outputs sampled 1 time unit after the rising edge.
// No backpressure involved: the stack accepts a command every cycle.
module tb_stack_unit;
    typedef struct {
        string      tag;
        logic [7:0] dout;
        logic [4:0] count;
        logic       ovf;
        logic       unf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   passed = 0;
    exp_t sb_q[$];

    stack_unit_if #(.WIDTH(8), .PTR_W(4)) bus ();

    stack_unit #(.WIDTH(8), .PTR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .s   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    endtask

    // Pop the oldest expectation and compare it against the DUT outputs.
    task automatic check_out();
        exp_t e;
        checks++;
        assert (sb_q.size() != 0) passed++;
        else begin
            $error("FAIL scoreboard_underrun: observed 0 entries expected 1");
            return;
        end
        e = sb_q.pop_front();
        cmp({e.tag, ".dout"},  bus.dout, e.dout);
        cmp({e.tag, ".count"}, {3'b000, bus.count}, {3'b000, e.count});
        cmp({e.tag, ".empty"}, {7'd0, bus.empty}, {7'd0, (e.count == 5'd0)});
        cmp({e.tag, ".full"},  {7'd0, bus.full},  {7'd0, (e.count == 5'd16)});
        cmp({e.tag, ".ovf"},   {7'd0, bus.overflow},  {7'd0, e.ovf});
        cmp({e.tag, ".unf"},   {7'd0, bus.underflow}, {7'd0, e.unf});
    endtask

    // Drive one command, queue its expected result, clock it, then check.
    task automatic step(input string tag, input logic r, input logic p, input logic po,
                        input logic t, input logic c, input logic [7:0] d,
                        input logic [7:0] ed, input logic [4:0] ec,
                        input logic eo, input logic eu);
        exp_t e;
        rst         = r;
        bus.push    = p;
        bus.pop     = po;
        bus.tos     = t;
        bus.clr_err = c;
        bus.din     = d;
        e.tag = tag; e.dout = ed; e.count = ec; e.ovf = eo; e.unf = eu;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        bus.push = 1'b0; bus.pop = 1'b0; bus.tos = 1'b0;
        bus.clr_err = 1'b0; bus.din = 8'h00;
        #1;
        // Reset state.
        step("reset", 1, 0, 0, 0, 0, 8'h00, 8'h00, 5'd0, 0, 0);

        // Basic LIFO order.
        step("push11", 0, 1, 0, 0, 0, 8'h11, 8'h00, 5'd1, 0, 0);
        step("push22", 0, 1, 0, 0, 0, 8'h22, 8'h00, 5'd2, 0, 0);
        step("push33", 0, 1, 0, 0, 0, 8'h33, 8'h00, 5'd3, 0, 0);
        step("tos33",  0, 0, 0, 1, 0, 8'h00, 8'h33, 5'd3, 0, 0);
        step("pop33",  0, 0, 1, 0, 0, 8'h00, 8'h33, 5'd2, 0, 0);
        step("pop22",  0, 0, 1, 0, 0, 8'h00, 8'h22, 5'd1, 0, 0);
        step("pop11",  0, 0, 1, 0, 0, 8'h00, 8'h11, 5'd0, 0, 0);

        // Fill to full, then overflow.
        for (int i = 0; i < 16; i++)
            step("fill", 0, 1, 0, 0, 0, 8'(i), 8'h11, 5'(i + 1), 0, 0);
        step("push_full", 0, 1, 0, 0, 0, 8'hAA, 8'h11, 5'd16, 1, 0);
        step("pop_0f",    0, 0, 1, 0, 0, 8'h00, 8'h0F, 5'd15, 1, 0);
        for (int i = 14; i >= 0; i--)
            step("drain", 0, 0, 1, 0, 0, 8'h00, 8'(i), 5'(i), 1, 0);

        // Underflow and flag clearing.
        step("pop_empty",   0, 0, 1, 0, 0, 8'h00, 8'h00, 5'd0, 1, 1);
        step("clr_pop",     0, 0, 1, 0, 1, 8'h00, 8'h00, 5'd0, 0, 1);
        step("clr_only",    0, 0, 0, 0, 1, 8'h00, 8'h00, 5'd0, 0, 0);

        // Replace-top.
        step("push05",  0, 1, 0, 0, 0, 8'h05, 8'h00, 5'd1, 0, 0);
        step("push07",  0, 1, 0, 0, 0, 8'h07, 8'h00, 5'd2, 0, 0);
        step("replace", 0, 1, 1, 0, 0, 8'h09, 8'h07, 5'd2, 0, 0);
        step("tos09",   0, 0, 0, 1, 0, 8'h00, 8'h09, 5'd2, 0, 0);
        step("pop09",   0, 0, 1, 0, 0, 8'h00, 8'h09, 5'd1, 0, 0);
        step("pop05",   0, 0, 1, 0, 0, 8'h00, 8'h05, 5'd0, 0, 0);

        // Push+pop on empty stack: pop rejected, push performed.
        step("pp_empty", 0, 1, 1, 0, 0, 8'h3C, 8'h05, 5'd1, 0, 1);
        step("pop3c",    0, 0, 1, 0, 0, 8'h00, 8'h3C, 5'd0, 0, 1);
        step("tos_empty",0, 0, 0, 1, 1, 8'h00, 8'h3C, 5'd0, 0, 0);

        // Reset mid-sequence overrides a pop.
        step("push44",  0, 1, 0, 0, 0, 8'h44, 8'h3C, 5'd1, 0, 0);
        step("push55",  0, 1, 0, 0, 0, 8'h55, 8'h3C, 5'd2, 0, 0);
        step("rst_pop", 1, 0, 1, 0, 0, 8'h00, 8'h00, 5'd0, 0, 0);
        step("push66",  0, 1, 0, 0, 0, 8'h66, 8'h00, 5'd1, 0, 0);
        step("tos66",   0, 0, 0, 1, 0, 8'h00, 8'h66, 5'd1, 0, 0);

        // Held tos keeps dout stable; tos with push returns old top.
        for (int i = 0; i < 3; i++)
            step("tos_hold", 0, 0, 0, 1, 0, 8'h00, 8'h66, 5'd1, 0, 0);
        step("push_tos", 0, 1, 0, 1, 0, 8'h77, 8'h66, 5'd2, 0, 0);
        step("tos77",    0, 0, 0, 1, 0, 8'h00, 8'h77, 5'd2, 0, 0);

        // All expectations must have been consumed.
        checks++;
        assert (sb_q.size() == 0) passed++;
        else $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb_q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/stack_unit.md
Name: stack_unit

Overview:
Hardware operand stack for the multicycle stack-machine datapath. It responds to the push/pop/tos strobes issued by the controller, one command per clock. It provides a registered top-of-stack output that feeds the A/B operand registers, plus status and sticky error flags. It is the responder end of the controller's stack-command interface.

Parameters:
WIDTH, 8, data word width in bits.
PTR_W, 4, pointer width; stack depth DEPTH = 2**PTR_W (default 16 entries).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
push  input  1  write din onto the stack this cycle.
pop  input  1  remove the top entry and load it into dout.
tos  input  1  copy the top entry into dout without removing it.
din  input  WIDTH  data to push (from the MtoS mux).
dout  output  WIDTH  registered top-of-stack / popped value.
count  output  PTR_W+1  number of valid entries, 0..DEPTH.
empty  output  1  count == 0 (combinational from count).
full  output  1  count == DEPTH (combinational from count).
overflow  output  1  sticky: a push was rejected because the stack was full.
underflow  output  1  sticky: a pop was rejected because the stack was empty.
clr_err  input  1  clears overflow and underflow.

Behaviour:
- Storage is a DEPTH x WIDTH register array. Entry i is valid for i < count. The top entry is mem[count-1].
- Reset: rst sampled high at a rising edge sets count=0, dout=0, overflow=0, underflow=0. Array contents are not cleared; the bench must not read them. Reset overrides every command issued in the same cycle, including a command mid-sequence.
- All commands complete in one cycle. The new dout and count are visible on the cycle after the edge. There is no handshake or busy signal; the controller may issue a command every cycle.
- Reads use the pre-edge array and count (read-before-write).
- Command resolution per edge (rst=0), with count denoted n:
  - push only, n<DEPTH: mem[n]<=din; count<=n+1; dout unchanged.
  - push only, n==DEPTH: array and count unchanged; overflow<=1.
  - pop only, n>0: dout<=mem[n-1]; count<=n-1.
  - pop only, n==0: dout and count unchanged; underflow<=1.
  - push+pop, n>0: replace top. dout<=mem[n-1] (old value); mem[n-1]<=din; count unchanged; no flag, including when n==DEPTH.
  - push+pop, n==0: the pop is rejected (underflow<=1) and the push is performed: mem[0]<=din; count<=1; dout unchanged.
- tos:
  - With n>0, tos loads dout<=mem[n-1] (pre-edge top). When combined with a push only, dout gets the old top, not din.
  - With n==0, tos leaves dout unchanged and raises no flag.
  - When pop is also asserted, pop determines dout; the value is identical, and tos adds no further effect.
- No command asserted: all state holds.
- Error flags are sticky until rst or clr_err. clr_err clears both flags at the edge. If a new error occurs in the same cycle as clr_err, the set wins for that flag and the other flag clears.
- count is never less than 0 or greater than DEPTH. There is no pointer wrap-around; the array index is count[PTR_W-1:0] for push and count-1 for reads.
- The controller holds tos high in most idle states. Continuous tos with no other command must keep dout stable at the current top.

Test Plan:
- Push 0x11, 0x22, 0x33 on consecutive cycles -> count=3, empty=0. Then tos -> dout=0x33. Then pop, pop, pop -> dout 0x33, 0x22, 0x11 on successive cycles; count=0, empty=1.
- Fill with 16 pushes of 0x00..0x0F -> full=1. A 17th push of 0xAA -> count stays 16, overflow=1. Pop -> dout=0x0F (0xAA not stored).
- Empty stack: pop -> underflow=1, dout unchanged. Next cycle clr_err with pop asserted -> underflow stays 1. Then clr_err alone -> underflow=0, overflow=0.
- Stack [0x05, 0x07] (top 0x07): push+pop with din=0x09 -> dout=0x07, count=2. Next tos -> dout=0x09.
- Empty stack: push+pop with din=0x3C -> count=1, underflow=1. Then pop -> dout=0x3C.
- Push 0x44, 0x55, then assert rst for one cycle together with a pop -> count=0, dout=0x00, flags 0. Then push 0x66 and tos -> dout=0x66.
